// File: rtl/inv_key_schedule_pkg.sv
// rtl/inv_key_schedule_pkg.sv - shared constants and helpers for the inverse AES key schedule
// Contents:
//   ST_IDLE/ST_EMIT/ST_STEP  FSM state encoding
//   SBOX                     forward AES S-box, entry 0 in the most significant byte
//   nr_of(nk)                number of rounds for a key of nk words
//   rcon(idx)                round constant byte for idx 1..10
//   sbox(x)                  forward S-box lookup
package inv_key_schedule_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EMIT = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic int nr_of(input int nk);
        return nk + 6;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] v;
        case (idx)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

endpackage

// File: rtl/inv_key_schedule_sub_word.sv
// rtl/inv_key_schedule_sub_word.sv - AES SubWord: four parallel forward S-boxes
// Ports:
//   i_word  32-bit input word
//   o_word  32-bit word with every byte substituted
module sub_word
    import inv_key_schedule_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    always_comb begin
        o_word = '0;
        for (int i = 0; i < 4; i++) begin
            o_word[8*i +: 8] = sbox(i_word[8*i +: 8]);
        end
    end

endmodule

// File: rtl/inv_key_schedule.sv
// rtl/inv_key_schedule.sv - inverse AES key schedule emitting round keys Nr down to 0
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   load_valid, load_ready   key load handshake, accepted only while idle
//   key_in                   last NK schedule words in key_in[NK*32-1:0], lowest index in MS word
//   rk_valid, rk_ready       round-key stream handshake
//   rk_out, rk_round         round key and its round number
//   rk_last                  set with round 0, the final key of a sequence
module inv_key_schedule
    import inv_key_schedule_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [255:0] key_in,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         rk_last
);

    localparam int         NR       = nr_of(NK);
    localparam logic [5:0] NK6      = 6'(NK);
    localparam logic [5:0] TOP_INIT = 6'(4 * (NR + 1) - 1);
    localparam logic [3:0] NR4      = 4'(NR);

    logic [1:0]  r_state;
    logic [31:0] r_win [NK];   // r_win[0] = w[b] ... r_win[NK-1] = w[top]
    logic [5:0]  r_top;
    logic [3:0]  r_round;
    logic [1:0]  r_step;

    logic [5:0]  w_jmod;
    logic [3:0]  w_jdiv;
    logic [31:0] w_t;
    logic [31:0] w_sub_in;
    logic [31:0] w_sub_out;
    logic [31:0] w_new;
    logic        w_rot;
    logic        w_sub_only;
    logic        w_unused_key;

    assign w_unused_key = ^key_in;

    assign w_jmod     = r_top % NK6;
    assign w_jdiv     = 4'(r_top / NK6);
    assign w_t        = r_win[NK-2];
    assign w_rot      = (w_jmod == 6'd0);
    assign w_sub_only = (NK == 8) && (w_jmod == 6'd4);

    // RotWord is a byte rotation, so one S-box bank serves both recurrence forms
    assign w_sub_in = w_rot ? {w_t[23:0], w_t[31:24]} : w_t;

    sub_word u_sub_word (
        .i_word (w_sub_in),
        .o_word (w_sub_out)
    );

    // Undo w[j] = w[j-NK] ^ f(w[j-1]) to recover w[j-NK]
    always_comb begin
        w_new = r_win[NK-1] ^ w_t;
        if (w_rot) begin
            w_new = r_win[NK-1] ^ w_sub_out ^ {rcon(w_jdiv), 24'h0};
        end else if (w_sub_only) begin
            w_new = r_win[NK-1] ^ w_sub_out;
        end
        // Indices below zero only pad the window for NK=6/8 and are never emitted
        if (r_top < NK6) begin
            w_new = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_top   <= '0;
            r_round <= '0;
            r_step  <= '0;
            for (int i = 0; i < NK; i++) begin
                r_win[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (load_valid) begin
                        for (int i = 0; i < NK; i++) begin
                            r_win[i] <= key_in[(NK-i)*32-1 -: 32];
                        end
                        r_top   <= TOP_INIT;
                        r_round <= NR4;
                        r_state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (rk_ready) begin
                        if (r_round == 4'd0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_STEP;
                            r_step  <= 2'd0;
                        end
                    end
                end
                ST_STEP: begin
                    r_win[0] <= w_new;
                    for (int i = 1; i < NK; i++) begin
                        r_win[i] <= r_win[i-1];
                    end
                    r_top  <= r_top - 6'd1;
                    r_step <= r_step + 2'd1;
                    if (r_step == 2'd3) begin
                        r_round <= r_round - 4'd1;
                        r_state <= ST_EMIT;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign load_ready = (r_state == ST_IDLE);
    assign rk_valid   = (r_state == ST_EMIT);
    assign rk_out     = {r_win[NK-4], r_win[NK-3], r_win[NK-2], r_win[NK-1]};
    assign rk_round   = r_round;
    assign rk_last    = (r_state == ST_EMIT) && (r_round == 4'd0);

endmodule

// File: tb/tb_inv_key_schedule.sv
// tb/tb_inv_key_schedule.sv - scoreboard bench for inv_key_schedule at NK=4/6/8
module tb_inv_key_schedule;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n = 1'b0;
    logic [2:0]        lv, lr, rv, rr, rl;
    logic [2:0][255:0] ki;
    logic [2:0][127:0] ro;
    logic [2:0][3:0]   rd;

    inv_key_schedule #(.NK(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv[0]), .load_ready(lr[0]), .key_in(ki[0]),
        .rk_valid(rv[0]), .rk_ready(rr[0]), .rk_out(ro[0]), .rk_round(rd[0]), .rk_last(rl[0]));
    inv_key_schedule #(.NK(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv[1]), .load_ready(lr[1]), .key_in(ki[1]),
        .rk_valid(rv[1]), .rk_ready(rr[1]), .rk_out(ro[1]), .rk_round(rd[1]), .rk_last(rl[1]));
    inv_key_schedule #(.NK(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv[2]), .load_ready(lr[2]), .key_in(ki[2]),
        .rk_valid(rv[2]), .rk_ready(rr[2]), .rk_out(ro[2]), .rk_round(rd[2]), .rk_last(rl[2]));

    typedef struct packed {
        logic [127:0] key;
        logic [3:0]   r;
        logic         last;
    } exp_t;

    exp_t        sbq0[$], sbq1[$], sbq2[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [7:0]  sb [256];
    logic [31:0] wexp [60];
    int          nk_of [3] = '{4, 6, 8};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int idx, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // ---- reference model: GF(2^8) S-box and forward key expansion ----
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rol(input logic [7:0] b, input int n);
        logic [7:0] v;
        v = b;
        for (int k = 0; k < n; k++) v = {v[6:0], v[7]};
        return v;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, x);
        return inv ^ rol(inv, 1) ^ rol(inv, 2) ^ rol(inv, 3) ^ rol(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    function automatic logic [255:0] rand256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic expand(input int nk, input logic [255:0] key);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) wexp[i] = key[(nk-i)*32-1 -: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = wexp[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            wexp[i] = wexp[i-nk] ^ t;
        end
    endtask

    task automatic set_rk(input int r, input logic [127:0] val);
        for (int k = 0; k < 4; k++) wexp[4*r+k] = val[127-32*k -: 32];
    endtask

    function automatic logic [255:0] load_vec(input int nk);
        logic [255:0] v;
        int total;
        total = 4 * (nk + 7);
        v = rand256();
        for (int k = 0; k < nk; k++) v[(nk-k)*32-1 -: 32] = wexp[total-nk+k];
        return v;
    endfunction

    function automatic int qsize(input int i);
        case (i)
            0:       return sbq0.size();
            1:       return sbq1.size();
            default: return sbq2.size();
        endcase
    endfunction

    task automatic push(input int i, input int nk);
        exp_t e;
        for (int r = nk + 6; r >= 0; r--) begin
            e.key  = {wexp[4*r], wexp[4*r+1], wexp[4*r+2], wexp[4*r+3]};
            e.r    = 4'(r);
            e.last = (r == 0);
            case (i)
                0:       sbq0.push_back(e);
                1:       sbq1.push_back(e);
                default: sbq2.push_back(e);
            endcase
        end
    endtask

    // ---- monitor ----
    logic [2:0]        prev_rv, prev_rr;
    logic [2:0][127:0] held_ro;
    logic [2:0][3:0]   held_rd;
    int                exp_rise [3];

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rv <= '0;
            prev_rr <= '0;
            for (int i = 0; i < 3; i++) exp_rise[i] <= -1;
        end else begin
            for (int i = 0; i < 3; i++) begin
                exp_t e;
                logic have;
                if (rv[i] && !prev_rv[i]) begin
                    chk("rise_cycle", i, 128'(cyc), 128'(exp_rise[i]));
                    chk("load_ready_busy", i, 128'(lr[i]), 128'd0);
                end
                if (prev_rv[i] && !prev_rr[i]) begin
                    chk("hold_valid", i, 128'(rv[i]), 128'd1);
                    chk("hold_key", i, ro[i], held_ro[i]);
                    chk("hold_round", i, 128'(rd[i]), 128'(held_rd[i]));
                end
                if (rv[i] && rr[i]) begin
                    have = (qsize(i) > 0);
                    e = '0;
                    if (have) begin
                        case (i)
                            0:       e = sbq0.pop_front();
                            1:       e = sbq1.pop_front();
                            default: e = sbq2.pop_front();
                        endcase
                        chk("rk_out", i, ro[i], e.key);
                        chk("rk_round", i, 128'(rd[i]), 128'(e.r));
                        chk("rk_last", i, 128'(rl[i]), 128'(e.last));
                    end else begin
                        chk("unexpected_key", i, 128'd1, 128'd0);
                    end
                    exp_rise[i] <= (have && e.last) ? -1 : cyc + 5;
                end
                if (lv[i] && lr[i]) exp_rise[i] <= cyc + 1;
            end
            prev_rv <= rv;
            prev_rr <= rr;
            held_ro <= ro;
            held_rd <= rd;
        end
    end

    // ---- stimulus ----
    task automatic load_key(input int i, input logic [255:0] kin);
        push(i, nk_of[i]);
        ki[i] = kin;
        lv[i] = 1'b1;
        @(posedge clk); #1;
        lv[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input int budget);
        int n;
        n = 0;
        while (!(lr[i] && qsize(i) == 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", i, 128'(n < budget), 128'd1);
    endtask

    task automatic wait_for(input logic [2:0] want_round, input bit want_last, input int budget);
        int n;
        n = 0;
        while (!(rv[0] && (want_last ? rl[0] : (rd[0] == 4'(want_round)))) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_timeout", 0, 128'(n < budget), 128'd1);
    endtask

    initial begin
        int  n;
        bit  stalled;
        for (int x = 0; x < 256; x++) sb[x] = sbox_calc(8'(x));
        lv = '0;
        rr = '0;
        ki = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_rk_valid", i, 128'(rv[i]), 128'd0);
            chk("reset_rk_out", i, ro[i], 128'd0);
            chk("reset_rk_round", i, 128'(rd[i]), 128'd0);
            chk("reset_rk_last", i, 128'(rl[i]), 128'd0);
            chk("reset_load_ready", i, 128'(lr[i]), 128'd1);
        end
        rst_n = 1'b1;

        // directed AES-128/192/256 with literal round keys
        rr = 3'b111;
        expand(4, 256'h2b7e151628aed2a6abf7158809cf4f3c);
        set_rk(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        set_rk(1, 128'ha0fafe1788542cb123a339392a6c7605);
        set_rk(0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        load_key(0, load_vec(4));
        wait_idle(0, 200);

        expand(6, 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b);
        set_rk(1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
        set_rk(0, 128'h8e73b0f7da0e6452c810f32b809079e5);
        load_key(1, load_vec(6));
        wait_idle(1, 200);

        expand(8, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
        set_rk(2, 128'h9ba354118e6925afa51a8b5f2067fcde);
        set_rk(1, 128'h1f352c073b6108d72d9810a30914dff4);
        set_rk(0, 128'h603deb1015ca71be2b73aef0857d7781);
        load_key(2, load_vec(8));
        wait_idle(2, 200);

        // backpressure: hold off round 7 for three cycles
        expand(4, rand256());
        load_key(0, load_vec(4));
        stalled = 0;
        n = 0;
        while (!(lr[0] && qsize(0) == 0) && n < 300) begin
            @(posedge clk); #1;
            n++;
            if (!stalled && rv[0] && rd[0] == 4'd7) begin
                rr[0] = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                rr[0] = 1'b1;
                stalled = 1;
            end
        end
        chk("bp_timeout", 0, 128'(n < 300), 128'd1);
        chk("bp_stalled", 0, 128'(stalled), 128'd1);

        // random keys and random rk_ready on all three widths at once
        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 0; i < 3; i++) begin
                expand(nk_of[i], rand256());
                load_key(i, load_vec(nk_of[i]));
            end
            n = 0;
            while (!(lr == 3'b111 && qsize(0) == 0 && qsize(1) == 0 && qsize(2) == 0) && n < 800) begin
                @(posedge clk); #1;
                n++;
                for (int i = 0; i < 3; i++) rr[i] = 1'($urandom_range(0, 1));
            end
            chk("rand_timeout", rep, 128'(n < 800), 128'd1);
        end
        rr = 3'b111;

        // load attempt while busy is ignored
        expand(4, rand256());
        load_key(0, load_vec(4));
        repeat (7) @(posedge clk);
        #1;
        chk("busy_load_ready", 0, 128'(lr[0]), 128'd0);
        ki[0] = rand256();
        lv[0] = 1'b1;
        @(posedge clk); #1;
        lv[0] = 1'b0;
        wait_idle(0, 200);

        // new load in the cycle right after the round-0 transfer
        expand(4, rand256());
        load_key(0, load_vec(4));
        wait_for(3'd0, 1'b1, 200);
        chk("lr_at_last", 0, 128'(lr[0]), 128'd0);
        @(posedge clk); #1;
        chk("lr_after_last", 0, 128'(lr[0]), 128'd1);
        expand(4, rand256());
        load_key(0, load_vec(4));
        wait_idle(0, 200);

        // reset in the middle of a STEP phase, then a fresh load
        expand(4, rand256());
        load_key(0, load_vec(4));
        wait_for(3'd5, 1'b0, 200);
        @(posedge clk); #1;
        rst_n = 1'b0;
        sbq0.delete();
        sbq1.delete();
        sbq2.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_rk_valid", 0, 128'(rv[0]), 128'd0);
        chk("rst_load_ready", 0, 128'(lr[0]), 128'd1);
        chk("rst_rk_round", 0, 128'(rd[0]), 128'd0);
        chk("rst_rk_out", 0, ro[0], 128'd0);
        expand(4, rand256());
        load_key(0, load_vec(4));
        wait_idle(0, 200);

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) chk("leftover_keys", i, 128'(qsize(i)), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog[0]: got timeout expected completion");
        $fatal(1);
    end

endmodule
